// File: rtl/ccff_chain_loader.sv
// Configuration-chain programming controller: serializes host words MSB-first onto
// ccff_head, gates the chain clock while shifting, and captures ccff_tail for readback.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(CHAIN_LEN + 1);
  localparam int WC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [WC_W-1:0]   pad;
  logic [WC_W-1:0]   len_nxt;
  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] rb_reg;
  logic              accept;
  logic              last_bit;
  logic              start_ok;

  // Bits still owed to the chain, capped at one host word; the last word may be short.
  function automatic logic [WC_W-1:0] word_len(input logic [BC_W-1:0] sent);
    int remaining;
    remaining = CHAIN_LEN - int'(sent);
    if (remaining >= WORD_W) return WC_W'(WORD_W);
    return WC_W'(remaining);
  endfunction

  // A short last word is captured into the LSBs; move it up so unused bits pad with zeros.
  function automatic logic [WORD_W-1:0] align_left(input logic [WORD_W-1:0] v,
                                                   input logic [WC_W-1:0]   sh);
    return v << sh;
  endfunction

  assign cfg_ready = (state == WAIT_WORD);
  assign accept    = (state == WAIT_WORD) && cfg_valid && !cfg_abort;
  assign last_bit  = (state == SHIFT) && (word_cnt == WC_W'(1));
  assign start_ok  = ((state == IDLE) || (state == DONE)) && cfg_start;
  assign len_nxt   = word_len(bit_cnt);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cfg_start) state_nxt = WAIT_WORD;
      WAIT_WORD: if (cfg_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (word_cnt == WC_W'(1)) begin
          if (int'(bit_cnt) == CHAIN_LEN - 1) state_nxt = DONE;
          else                                state_nxt = WAIT_WORD;
        end
      end
      DONE:      if (cfg_start) state_nxt = WAIT_WORD;
      default:   state_nxt = IDLE;
    endcase
    if (cfg_abort) state_nxt = IDLE;
  end

  // Control and registered outputs
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      pad           <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      ccff_shift_en <= (state_nxt == SHIFT);
      busy          <= (state_nxt == WAIT_WORD) || (state_nxt == SHIFT);
      done          <= (state_nxt == DONE);
      rd_valid      <= last_bit && !cfg_abort;

      if (last_bit && !cfg_abort)
        rd_data <= align_left({rb_reg[WORD_W-2:0], ccff_tail}, pad);

      if (accept)
        ccff_head <= cfg_data[WORD_W-1];
      else if ((state == SHIFT) && !last_bit && !cfg_abort)
        ccff_head <= word_reg[WORD_W-2];
      else
        ccff_head <= 1'b0;

      if ((state == IDLE) || start_ok)
        bit_cnt <= '0;
      else if ((state == SHIFT) && !cfg_abort && (int'(bit_cnt) < CHAIN_LEN))
        bit_cnt <= bit_cnt + BC_W'(1);

      if (accept) begin
        word_cnt <= len_nxt;
        pad      <= WC_W'(WORD_W) - len_nxt;
      end else if (state == SHIFT) begin
        word_cnt <= word_cnt - WC_W'(1);
      end
    end
  end

  // Word and readback shift registers
  always_ff @(posedge prog_clk) begin
    if (accept)
      word_reg <= cfg_data;
    else if (state == SHIFT)
      word_reg <= word_reg << 1;

    if ((state == IDLE) || accept)
      rb_reg <= '0;
    else if (state == SHIFT)
      rb_reg <= {rb_reg[WORD_W-2:0], ccff_tail};
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural 36-bit chain model plus a readback scoreboard.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 36;
  localparam int WORD_W    = 8;

  logic              prog_clk = 1'b0;
  logic              pReset = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_abort = 1'b0;
  logic [WORD_W-1:0] cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters bit 0, tail leaves from bit 35.
  logic [CHAIN_LEN-1:0] chain;
  logic                 chain_clr = 1'b0;
  always @(posedge prog_clk) begin
    if (chain_clr)          chain <= '0;
    else if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int shifts = 0;
  int rd_cnt = 0;
  int done_cyc = 0;
  int stall_shifts = 0;
  bit timeout = 1'b0;
  logic [WORD_W-1:0] sb_q[$];

  // One clock; afterwards outputs are sampled and any readback is scored.
  task automatic tick();
    logic [WORD_W-1:0] exp;
    @(posedge prog_clk);
    #1;
    cyc++;
    if (ccff_shift_en) shifts++;
    if (rd_valid) begin
      rd_cnt++;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: rd_valid with rd_data=%h, required no strobe", rd_data);
      end else begin
        exp = sb_q.pop_front();
        if (rd_data !== exp) begin
          fails++;
          $display("FAIL rd_data: got %h, required %h", rd_data, exp);
        end
      end
    end
  endtask

  // Expected readback word k: bits leave the tail in order chain[35], chain[34], ...
  function automatic logic [WORD_W-1:0] rb_word(input logic [CHAIN_LEN-1:0] prev, input int k);
    logic [WORD_W-1:0] r;
    int len;
    r = '0;
    len = (CHAIN_LEN - WORD_W * k < WORD_W) ? CHAIN_LEN - WORD_W * k : WORD_W;
    for (int j = 0; j < len; j++) r[WORD_W-1-j] = prev[CHAIN_LEN-1-WORD_W*k-j];
    return r;
  endfunction

  task automatic drive_load(input logic [WORD_W-1:0] w[5], input int stall_word,
                            input int abort_after, input bit ign_start);
    logic [CHAIN_LEN-1:0] prev;
    int guard;
    int t0;
    bit aborted;
    prev = chain;
    shifts = 0;
    rd_cnt = 0;
    timeout = 1'b0;
    stall_shifts = 0;
    aborted = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 5 && !aborted; k++) begin
      if (k == stall_word) begin
        cfg_valid = 1'b0;
        repeat (7) begin
          tick();
          if (ccff_shift_en) stall_shifts++;
        end
      end
      guard = 0;
      while (!cfg_ready && guard < 50) begin
        tick();
        guard++;
      end
      cfg_data = w[k];
      cfg_valid = 1'b1;
      sb_q.push_back(rb_word(prev, k));
      tick();
      cfg_valid = 1'b0;
      guard = 0;
      while (!cfg_ready && !done && !aborted && guard < 50) begin
        if (abort_after > 0 && shifts == abort_after) begin
          cfg_abort = 1'b1;
          tick();
          cfg_abort = 1'b0;
          aborted = 1'b1;
        end else begin
          cfg_start = ign_start && (shifts == 10);
          tick();
          cfg_start = 1'b0;
        end
        guard++;
      end
      if (guard >= 50) timeout = 1'b1;
    end
    done_cyc = cyc - t0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({cfg_ready, ccff_head, ccff_shift_en, rd_valid, busy, done} !== 6'b0 || rd_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b head=%b sh=%b rv=%b busy=%b done=%b rd=%h, required all 0",
               cfg_ready, ccff_head, ccff_shift_en, rd_valid, busy, done, rd_data);
    end
    chain_clr = 1'b1;
    @(negedge prog_clk);
    @(negedge prog_clk);
    pReset = 1'b1;
    tick();
    chain_clr = 1'b0;
    tick();
    tests++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0 || chain !== '0) begin
      fails++;
      $display("FAIL reset_idle: got rdy=%b busy=%b chain=%h, required 0 0 0", cfg_ready, busy, chain);
    end
  endtask

  task automatic check_complete(input string name, input logic [CHAIN_LEN-1:0] exp_chain,
                                input int exp_cyc);
    tests++;
    if (timeout || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: got done=%b busy=%b timeout=%b, required 1 0 0", name, done, busy, timeout);
    end
    tests++;
    if (chain !== exp_chain) begin
      fails++;
      $display("FAIL %s_chain: got %h, required %h", name, chain, exp_chain);
    end
    tests++;
    if (shifts != CHAIN_LEN || rd_cnt != 5 || sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_counts: got shifts=%0d rd=%0d left=%0d, required 36 5 0",
               name, shifts, rd_cnt, sb_q.size());
    end
    if (exp_cyc > 0) begin
      tests++;
      if (done_cyc != exp_cyc) begin
        fails++;
        $display("FAIL %s_latency: got done at %0d, required %0d", name, done_cyc, exp_cyc);
      end
    end
    sb_q.delete();
  endtask

  task automatic test_full_load();
    logic [WORD_W-1:0] w[5];
    w = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h9C};
    drive_load(w, -1, 0, 1'b0);
    check_complete("full_load", 36'hA53CFF009, 41);
  endtask

  task automatic test_readback();
    logic [WORD_W-1:0] w[5];
    w = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90};
    sb_q.delete();
    drive_load(w, -1, 0, 1'b0);
    check_complete("readback", 36'h123456789, 41);
  endtask

  task automatic test_stall();
    logic [WORD_W-1:0] w[5];
    w = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h93};
    drive_load(w, 2, 0, 1'b0);
    tests++;
    if (stall_shifts != 0) begin
      fails++;
      $display("FAIL stall_shift_en: got %0d shift cycles while stalled, required 0", stall_shifts);
    end
    check_complete("stall", 36'hA53CFF009, 48);
  endtask

  task automatic test_abort();
    logic [WORD_W-1:0] w[5];
    w = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90};
    drive_load(w, -1, 13, 1'b0);
    tests++;
    if ({ccff_shift_en, rd_valid, busy, done, cfg_ready} !== 5'b0) begin
      fails++;
      $display("FAIL abort_idle: got sh=%b rv=%b busy=%b done=%b rdy=%b, required all 0",
               ccff_shift_en, rd_valid, busy, done, cfg_ready);
    end
    repeat (5) tick();
    tests++;
    if (shifts != 13 || rd_cnt != 1 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_counts: got shifts=%0d rd=%0d done=%b, required 13 1 0", shifts, rd_cnt, done);
    end
    sb_q.delete();
  endtask

  task automatic test_ignored_start();
    logic [WORD_W-1:0] w[5];
    w = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h6E};
    drive_load(w, -1, 0, 1'b1);
    check_complete("ignored_start", 36'h5AC30FF06, 41);
  endtask

  task automatic test_reset_mid_shift();
    logic [CHAIN_LEN-1:0] snap;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_data = 8'hB7;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    #2 pReset = 1'b0;
    #1;
    tests++;
    if ({cfg_ready, ccff_head, ccff_shift_en, rd_valid, busy, done} !== 6'b0 || rd_data !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got rdy=%b head=%b sh=%b rv=%b busy=%b done=%b rd=%h, required all 0",
               cfg_ready, ccff_head, ccff_shift_en, rd_valid, busy, done, rd_data);
    end
    snap = chain;
    shifts = 0;
    #3 pReset = 1'b1;
    repeat (4) tick();
    tests++;
    if (shifts != 0 || chain !== snap || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_idle: got shifts=%0d busy=%b rdy=%b chain=%h, required 0 0 0 %h",
               shifts, busy, cfg_ready, chain, snap);
    end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_readback();
    test_stall();
    test_abort();
    test_ignored_start();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain programming controller for the switch-block and connection-block memories. It accepts configuration words from the bitstream host over a valid/ready handshake and serializes them MSB-first onto `ccff_head`, one bit per cycle. It asserts a shift enable that drives the chain's clock-gating cell, and captures the bits falling out of `ccff_tail` so the previous contents can be read back. One instance drives one chain: `ccff_head` of the first `mux_*_mem` cell and `ccff_tail` of the last.

## Interface
- `CHAIN_LEN`, 36, total configuration bits in the chain (18 two-bit mux memories).
- `WORD_W`, 8, host word width.
- `prog_clk` input 1: configuration clock; all state updates on its rising edge.
- `pReset` input 1: asynchronous, active-low reset.
- `cfg_start` input 1: one-cycle start request; honoured only in IDLE or DONE.
- `cfg_abort` input 1: synchronous abort; returns the block to IDLE from any state.
- `cfg_data` input WORD_W: host configuration word; the MSB is shifted first.
- `cfg_valid` input 1: `cfg_data` is valid.
- `cfg_ready` output 1: the block accepts `cfg_data` this cycle.
- `ccff_head` output 1: serial data to the chain head.
- `ccff_shift_en` output 1: chain clock-gate enable; the chain shifts on every `prog_clk` edge while this is high.
- `ccff_tail` input 1: serial data from the chain tail.
- `rd_data` output WORD_W: readback word, MSB = first bit captured.
- `rd_valid` output 1: one-cycle strobe, `rd_data` is valid.
- `busy` output 1: high in WAIT_WORD or SHIFT.
- `done` output 1: high in DONE.

## Operation
- State machine: IDLE, WAIT_WORD, SHIFT, DONE.
- **IDLE**
  - `cfg_start` moves the block to WAIT_WORD.
  - Clears the bit counter `bit_cnt` and the readback register.
- **WAIT_WORD**
  - `cfg_ready`=1.
  - On `cfg_valid`&&`cfg_ready`:
    - Load the word register with `cfg_data`.
    - Load the in-word counter with `min(WORD_W, CHAIN_LEN-bit_cnt)`.
    - Go to SHIFT.
  - If `cfg_valid` is low, stay in WAIT_WORD. `ccff_shift_en` stays 0, so the chain holds.
- **SHIFT** (each cycle):
  - `ccff_shift_en`=1, `ccff_head`=word_reg[WORD_W-1].
  - Shift `word_reg` left by 1.
  - Shift `ccff_tail` into the LSB of the readback register.
  - Increment `bit_cnt`; decrement the in-word counter.
  - When the in-word counter reaches 0:
    - If `bit_cnt`==CHAIN_LEN, go to DONE.
    - Otherwise, go to WAIT_WORD.
- **Last word**
  - When CHAIN_LEN mod WORD_W ≠ 0, only the upper `CHAIN_LEN mod WORD_W` bits of the last word are used.
  - The remaining bits are discarded.
- **Readback**
  - `rd_valid` pulses on the cycle after the final shift of each word.
  - A partial last word is presented left-aligned, with zero padding in the LSBs.
- **DONE**
  - `done`=1; the state is held.
  - `cfg_start` starts a new load and goes to WAIT_WORD.
- **Abort**
  - `cfg_abort` has priority over every other event.
  - Next cycle the block is in IDLE with `ccff_shift_en`=0 and no `rd_valid`.
  - The chain holds a partially shifted state; the host must reload it.
- **Ignored inputs**
  - `cfg_start` is ignored while `busy`.
  - `cfg_valid` is ignored outside WAIT_WORD.
- **Arithmetic**
  - `bit_cnt` is `$clog2(CHAIN_LEN+1)` bits wide and never wraps.
  - The in-word counter is `$clog2(WORD_W+1)` bits wide.

## Timing
- **Reset** (pReset low): outputs take these values immediately.
  - State = IDLE.
  - `cfg_ready`=0, `ccff_head`=0, `ccff_shift_en`=0.
  - `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0.
- **Mid-load reset**: same as abort; no further shifting occurs.
- All outputs are registered except `cfg_ready`, which is decoded from state.
- **Start**: `cfg_start` at cycle t puts the block in WAIT_WORD at t+1 (`cfg_ready`=1).
- **Word accept to first bit**: a word accepted at cycle a drives its first bit at cycle a+1. The chain captures that bit on the edge ending cycle a+1.
- **Throughput**
  - With `cfg_valid` held high, each full word costs WORD_W+1 cycles, including one accept bubble.
  - A full load takes CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) cycles after WAIT_WORD entry. This is 41 cycles at default parameters.
- **Readback sampling**: `ccff_tail` is sampled in the same cycle `ccff_shift_en`=1, so the captured value is the pre-edge tail bit.
- **Done**: `done` rises the cycle after the final shift, coincident with the last `rd_valid`.

## Test plan
- **Reset mid-shift**: drop `pReset` during SHIFT -> all outputs are 0 asynchronously; after release the block is in IDLE and no shift edges occur.
- **Full load with chain model**
  - Setup: a behavioural 36-bit chain model preloaded with 0; start; send words 0xA5, 0x3C, 0xFF, 0x00, 0x9_ (upper nibble 9), `cfg_valid` held high.
  - Required response:
    - The chain holds 0xA53CFF009.
    - Exactly 36 shift cycles; `done` at cycle 41 after WAIT_WORD entry.
    - Five `rd_valid` pulses, all `rd_data`=0x00.
- **Readback of previous load**: repeat the load with words 0x12, 0x34, 0x56, 0x78, 0x90 -> `rd_data` sequence is 0xA5, 0x3C, 0xFF, 0x00, 0x90.
- **Host stall**: deassert `cfg_valid` for 7 cycles between words 2 and 3 -> `ccff_shift_en`=0 for those cycles; final chain contents unchanged from the unstalled case.
- **Abort**: assert `cfg_abort` after the 13th shift -> IDLE next cycle, exactly 13 shift cycles total, `done`=0.
- **Ignored start**: `cfg_start` pulsed while `busy` -> ignored; the load completes normally.
